// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i fetch stage: PC, in-order imem requests, response FIFO, redirect flush
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (halt fetch on a misaligned redirect target)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcPlus4,
  output logic        misaligned
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   depthLimit = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] depthFull  = CW'(DEPTH);
  localparam logic [PW-1:0] lastIdx    = PW'(DEPTH - 1);
  localparam logic [31:0]   nopInstr   = 32'h0000_0013;

  typedef enum logic {RUN, HALT} fetchState;

  fetchState     state;
  logic [31:0]   pc;
  logic [31:0]   respPc;
  logic [CW-1:0] outCnt;
  logic [CW-1:0] dropCnt;
  logic [CW-1:0] fillCnt;
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [31:0]   fifoInstr [DEPTH];
  logic [31:0]   fifoPc    [DEPTH];

  logic          running;
  logic          issue;
  logic          push;
  logic          pop;
  logic          discard;
  logic          trap;
  logic          bufEmpty;
  logic [31:0]   targetPc;

  function automatic logic [PW-1:0] nextIdx(input logic [PW-1:0] idx);
    return (idx == lastIdx) ? '0 : idx + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  assign targetPc = redirect_pc;
  assign trap     = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign targetPc = redirect_pc & 32'hFFFF_FFFC;
  assign trap     = 1'b0;
`endif

  assign running  = (state == RUN);
  assign bufEmpty = (fillCnt == '0);

  // Issue looks only at registered counts so the request never depends on this cycle's response
  assign issue   = running && !reset && !redirect &&
                   (({1'b0, outCnt} + {1'b0, fillCnt}) < depthLimit);
  assign discard = imem_rvalid && (dropCnt != '0);
  assign push    = imem_rvalid && (dropCnt == '0) && !redirect && running;
  assign pop     = instr_valid && instr_ready && !redirect;

  assign imem_req      = issue;
  assign imem_addr     = pc;
  assign instr_valid   = running && !bufEmpty;
  assign instr         = bufEmpty ? nopInstr : fifoInstr[headPtr];
  assign instr_pc      = bufEmpty ? respPc : fifoPc[headPtr];
  assign instr_pcPlus4 = instr_pc + 32'd4;

  // Counters, pointers and PCs: redirect flushes and re-targets, otherwise apply net deltas
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      respPc  <= RESET_PC;
      outCnt  <= '0;
      dropCnt <= '0;
      fillCnt <= '0;
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      outCnt <= outCnt + CW'(issue) - CW'(imem_rvalid);
      if (redirect) begin
        pc      <= targetPc;
        respPc  <= targetPc;
        dropCnt <= outCnt - CW'(imem_rvalid);
        fillCnt <= '0;
        headPtr <= '0;
        tailPtr <= '0;
      end else begin
        if (issue) pc <= pc + 32'd4;
        if (push) begin
          respPc  <= respPc + 32'd4;
          tailPtr <= nextIdx(tailPtr);
        end
        if (pop) headPtr <= nextIdx(headPtr);
        dropCnt <= dropCnt - CW'(discard);
        fillCnt <= fillCnt + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage, written only on an accepted response
  always_ff @(posedge clk) begin
    if (push) begin
      fifoInstr[tailPtr] <= imem_rdata;
      fifoPc[tailPtr]    <= respPc;
    end
  end

  // Run/halt FSM with sticky misaligned flag; halt is left only through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      misaligned <= 1'b0;
    end else if (trap) begin
      state      <= HALT;
      misaligned <= 1'b1;
    end
  end

  // Outstanding plus buffered never exceeds DEPTH, so a push into a full FIFO is a bug
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && fillCnt == depthFull));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcPlus4;
  logic        misaligned;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  int lat = 1;
  int reqCount;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } respT;
  respT respQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pcPlus4(instr_pcPlus4),
    .misaligned(misaligned)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    if (a == 32'h0000_0104) return 32'h00a0_0113;
    return a ^ 32'h1234_5673;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int l, input logic rdy);
    tick();
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = rdy;
    lat = l;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Instruction memory: fixed latency, in-order, cleared by reset
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (respQ.size() > 0 && respQ[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata = memWord(respQ[0].addr);
        void'(respQ.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      if (reset) respQ.delete();
      else if (imem_req) respQ.push_back('{due: cyc + lat, addr: imem_addr});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    repeat (3) tick();

    // Reset values
    @(negedge clk);
    checkVal("rst_req", imem_req, 0);
    checkVal("rst_addr", imem_addr, 32'h100);
    checkVal("rst_valid", instr_valid, 0);
    checkVal("rst_instr", instr, 32'h13);
    checkVal("rst_pc", instr_pc, 32'h100);
    checkVal("rst_pc4", instr_pcPlus4, 32'h104);
    checkVal("rst_mis", misaligned, 0);

    // L=1, ready=1: one fetch per cycle, first valid at cycle 2
    doReset(1, 1'b1);
    @(negedge clk);
    checkVal("t1_c0_req", imem_req, 1);
    checkVal("t1_c0_addr", imem_addr, 32'h100);
    checkVal("t1_c0_valid", instr_valid, 0);
    tick(); @(negedge clk);
    checkVal("t1_c1_addr", imem_addr, 32'h104);
    checkVal("t1_c1_valid", instr_valid, 0);
    tick(); @(negedge clk);
    checkVal("t1_c2_valid", instr_valid, 1);
    checkVal("t1_c2_instr", instr, 32'h0050_0093);
    checkVal("t1_c2_pc", instr_pc, 32'h100);
    checkVal("t1_c2_pc4", instr_pcPlus4, 32'h104);
    checkVal("t1_c2_addr", imem_addr, 32'h108);
    tick(); @(negedge clk);
    checkVal("t1_c3_instr", instr, 32'h00a0_0113);
    checkVal("t1_c3_pc", instr_pc, 32'h104);

    // Backpressure: DEPTH=4 caps requests, then four consecutive pops
    doReset(1, 1'b0);
    reqCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) reqCount++;
      if (i == 9) checkVal("t2_req_stalled", imem_req, 0);
      tick();
    end
    checkVal("t2_req_count", reqCount, 4);
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkVal("t2_pop_valid", instr_valid, 1);
      checkVal("t2_pop_pc", instr_pc, 32'h100 + 32'(4 * k));
      checkVal("t2_pop_instr", instr, memWord(32'h100 + 32'(4 * k)));
      tick();
    end

    // L=3 redirect with 2 in flight, 1 buffered, coinciding with pop and response
    doReset(3, 1'b0);
    repeat (4) tick();
    instr_ready = 1'b1;
    @(negedge clk);
    checkVal("t3_c4_pc", instr_pc, 32'h100);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    checkVal("t3_c5_pc", instr_pc, 32'h104);
    checkVal("t3_c5_req", imem_req, 0);
    tick();
    redirect = 1'b0;
    for (int c = 6; c < 10; c++) begin
      @(negedge clk);
      checkVal("t3_flush_valid", instr_valid, 0);
      if (c == 6) begin
        checkVal("t3_c6_req", imem_req, 1);
        checkVal("t3_c6_addr", imem_addr, 32'h40);
        checkVal("t3_c6_instr", instr, 32'h13);
      end
      tick();
    end
    @(negedge clk);
    checkVal("t3_c10_valid", instr_valid, 1);
    checkVal("t3_c10_pc", instr_pc, 32'h40);
    checkVal("t3_c10_instr", instr, memWord(32'h40));
    checkVal("t3_c10_pc4", instr_pcPlus4, 32'h44);
    tick(); @(negedge clk);
    checkVal("t3_c11_pc", instr_pc, 32'h44);

    // PC wrap at the top of the address space
    doReset(1, 1'b1);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    checkVal("t4_c0_req", imem_req, 0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checkVal("t4_c1_addr", imem_addr, 32'hFFFF_FFF8);
    tick(); @(negedge clk);
    checkVal("t4_c2_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    checkVal("t4_c3_addr", imem_addr, 32'h0);
    checkVal("t4_c3_pc", instr_pc, 32'hFFFF_FFF8);
    tick(); @(negedge clk);
    checkVal("t4_c4_pc", instr_pc, 32'hFFFF_FFFC);
    checkVal("t4_c4_pc4", instr_pcPlus4, 32'h0);
    tick(); @(negedge clk);
    checkVal("t4_c5_pc", instr_pc, 32'h0);
    checkVal("t4_c5_instr", instr, memWord(32'h0));

    // Misaligned redirect target
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h42;
    @(negedge clk);
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkVal("t5_mis", misaligned, 1);
      checkVal("t5_req", imem_req, 0);
      checkVal("t5_valid", instr_valid, 0);
      tick();
    end
`else
    @(negedge clk);
    checkVal("t5_mis", misaligned, 0);
    checkVal("t5_req", imem_req, 1);
    checkVal("t5_addr", imem_addr, 32'h40);
    tick(); @(negedge clk);
    checkVal("t5_c8_valid", instr_valid, 0);
    tick(); @(negedge clk);
    checkVal("t5_c9_valid", instr_valid, 1);
    checkVal("t5_c9_pc", instr_pc, 32'h40);
    checkVal("t5_c9_instr", instr, memWord(32'h40));
    tick();
`endif

    // Reset in the middle of operation
    reset = 1'b1;
    tick();
    @(negedge clk);
    checkVal("rst2_req", imem_req, 0);
    checkVal("rst2_addr", imem_addr, 32'h100);
    checkVal("rst2_valid", instr_valid, 0);
    checkVal("rst2_instr", instr, 32'h13);
    checkVal("rst2_pc", instr_pc, 32'h100);
    checkVal("rst2_mis", misaligned, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkVal("rst2_c0_req", imem_req, 1);
    checkVal("rst2_c0_addr", imem_addr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
